// File: rtl/ham_pkg.sv
// Shared Hamming(15,11) definitions: code geometry, pipeline occupancy
// states and the syndrome / data-extraction helpers.
package ham_pkg;

   localparam int HAM_CW_W   = 15;
   localparam int HAM_DATA_W = 11;
   localparam int HAM_SYN_W  = 4;

   // Occupancy of the two-stage pipeline (S0 capture, S1 correct/hold)
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_t;

   // Data bits live at Hamming positions 3,5,6,7,9..15 (cw[p-1] is position p)
   function automatic logic [HAM_DATA_W-1:0] ham_extract_data(input logic [HAM_CW_W-1:0] cw);
      return {cw[14:8], cw[6:4], cw[2]};
   endfunction

   // Syndrome is the XOR of the position numbers of all set bits
   function automatic logic [HAM_SYN_W-1:0] ham_syndrome(input logic [HAM_CW_W-1:0] cw);
      logic [HAM_SYN_W-1:0] syn;
      syn = 4'd0;
      for (int p = 1; p <= HAM_CW_W; p++) begin
         if (cw[p-1]) begin
            syn = syn ^ HAM_SYN_W'(p);
         end else begin
            syn = syn;
         end
      end
      return syn;
   endfunction

endpackage

// File: rtl/ham15_correct.sv
// Combinational Hamming(15,11) single-error corrector. A non-zero syndrome
// names the faulty position, which may be a data or a parity bit.
module ham15_correct
   import ham_pkg::*;
(
   input  logic [HAM_CW_W-1:0]   cw,
   output logic [HAM_SYN_W-1:0]  syn,
   output logic [HAM_CW_W-1:0]   cw_corr,
   output logic [HAM_DATA_W-1:0] data,
   output logic                  err
);

   // Compute syndrome, flip the indicated bit and extract the data field
   always_comb begin
      syn = ham_syndrome(cw);
      if (syn != 4'd0) begin
         err     = 1'b1;
         cw_corr = cw ^ (15'd1 << (syn - 4'd1));
      end else begin
         err     = 1'b0;
         cw_corr = cw;
      end
      data = ham_extract_data(cw_corr);
   end

endmodule

// File: rtl/ham_dec_arbiter.sv
// Round-robin shared Hamming(15,11) decoder. Requests are arbitrated into
// stage S0; S1 corrects the word and holds the tagged response until taken.
// Optional corrected-error counter is built when HAM_ERR_CNT_EN is defined.
module ham_dec_arbiter
   import ham_pkg::*;
#(
   parameter  int NREQ  = 2,
`ifdef HAM_ERR_CNT_EN
   parameter  int CNT_W = 8,
`endif
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*HAM_CW_W-1:0] req_cw,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [HAM_DATA_W-1:0]    rsp_data,
   output logic [HAM_CW_W-1:0]      rsp_cw,
   output logic [HAM_SYN_W-1:0]     rsp_syn,
`ifdef HAM_ERR_CNT_EN
   output logic [CNT_W-1:0]         err_cnt,
   input  logic                     err_cnt_clr,
`endif
   output logic                     rsp_err
);

   logic [IDW-1:0]        rr_r;
   logic                  s0_vld_r;
   logic [HAM_CW_W-1:0]   s0_cw_r;
   logic [IDW-1:0]        s0_id_r;
   occ_state_t            occ_r;

   logic [NREQ-1:0]       grant_s;
   logic [IDW-1:0]        grant_id_s;
   logic [HAM_CW_W-1:0]   grant_cw_s;
   logic                  any_grant_s;
   logic                  s0_load_s;
   logic                  s1_move_s;
   logic                  req_fire_s;
   logic                  s0_vld_nxt_s;
   logic                  s1_vld_nxt_s;
   occ_state_t            occ_nxt_s;

   logic [HAM_SYN_W-1:0]  corr_syn_s;
   logic [HAM_CW_W-1:0]   corr_cw_s;
   logic [HAM_DATA_W-1:0] corr_data_s;
   logic                  corr_err_s;

   // Round-robin pick: first valid at or above the pointer, else wrap to the lowest
   always_comb begin
      grant_s     = {NREQ{1'b0}};
      grant_id_s  = {IDW{1'b0}};
      grant_cw_s  = {HAM_CW_W{1'b0}};
      any_grant_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any_grant_s && req_valid[i] && (i >= int'(rr_r))) begin
            grant_s[i]  = 1'b1;
            grant_id_s  = IDW'(i);
            grant_cw_s  = req_cw[HAM_CW_W*i +: HAM_CW_W];
            any_grant_s = 1'b1;
         end else begin
            any_grant_s = any_grant_s;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!any_grant_s && req_valid[i] && (i < int'(rr_r))) begin
            grant_s[i]  = 1'b1;
            grant_id_s  = IDW'(i);
            grant_cw_s  = req_cw[HAM_CW_W*i +: HAM_CW_W];
            any_grant_s = 1'b1;
         end else begin
            any_grant_s = any_grant_s;
         end
      end
   end

   // Stage-advance rules and next occupancy; S0 can load unless both stages are stuck
   always_comb begin
      s1_move_s = !rsp_valid || rsp_ready;
      if (occ_r != OCC_FULL) begin
         s0_load_s = 1'b1;
      end else begin
         s0_load_s = rsp_ready;
      end
      req_ready    = (rst_n && s0_load_s) ? grant_s : {NREQ{1'b0}};
      req_fire_s   = s0_load_s && any_grant_s;
      if (req_fire_s) begin
         s0_vld_nxt_s = 1'b1;
      end else if (s1_move_s) begin
         s0_vld_nxt_s = 1'b0;
      end else begin
         s0_vld_nxt_s = s0_vld_r;
      end
      s1_vld_nxt_s = s1_move_s ? s0_vld_r : rsp_valid;
      case ({s0_vld_nxt_s, s1_vld_nxt_s})
         2'b00:   occ_nxt_s = OCC_EMPTY;
         2'b01:   occ_nxt_s = OCC_ONE;
         2'b10:   occ_nxt_s = OCC_ONE;
         2'b11:   occ_nxt_s = OCC_FULL;
         default: occ_nxt_s = OCC_EMPTY;
      endcase
   end

   ham15_correct u_correct (
      .cw      (s0_cw_r),
      .syn     (corr_syn_s),
      .cw_corr (corr_cw_s),
      .data    (corr_data_s),
      .err     (corr_err_s)
   );

   // Round-robin pointer advances past the winner only on a completed handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_r <= {IDW{1'b0}};
      end else if (req_fire_s) begin
         if (grant_id_s == IDW'(NREQ-1)) begin
            rr_r <= {IDW{1'b0}};
         end else begin
            rr_r <= grant_id_s + IDW'(1);
         end
      end
   end

   // Pipeline registers: S0 captures the granted word, S1 holds the corrected response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r     <= OCC_EMPTY;
         s0_vld_r  <= 1'b0;
         s0_cw_r   <= {HAM_CW_W{1'b0}};
         s0_id_r   <= {IDW{1'b0}};
         rsp_valid <= 1'b0;
         rsp_id    <= {IDW{1'b0}};
         rsp_data  <= {HAM_DATA_W{1'b0}};
         rsp_cw    <= {HAM_CW_W{1'b0}};
         rsp_syn   <= {HAM_SYN_W{1'b0}};
         rsp_err   <= 1'b0;
      end else begin
         occ_r     <= occ_nxt_s;
         s0_vld_r  <= s0_vld_nxt_s;
         rsp_valid <= s1_vld_nxt_s;
         if (req_fire_s) begin
            s0_cw_r <= grant_cw_s;
            s0_id_r <= grant_id_s;
         end
         if (s1_move_s && s0_vld_r) begin
            rsp_id   <= s0_id_r;
            rsp_data <= corr_data_s;
            rsp_cw   <= corr_cw_s;
            rsp_syn  <= corr_syn_s;
            rsp_err  <= corr_err_s;
         end
      end
   end

`ifdef HAM_ERR_CNT_EN
   logic rsp_fire_s;
   assign rsp_fire_s = rsp_valid && rsp_ready;

   // Saturating count of corrected responses; clear has priority over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= {CNT_W{1'b0}};
      end else if (err_cnt_clr) begin
         err_cnt <= {CNT_W{1'b0}};
      end else if (rsp_fire_s && rsp_err && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
